// File: rtl/uart_tx_if.sv
// Host-side write port of the UART transmitter: valid/ready byte push plus a drop indication.
interface uart_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ready;
  logic       overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  ready,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output ready,
    output overflow
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (LSB first, 1 or 2 stop bits) fed by a small byte FIFO.
// tx is registered from the current state, so the line trails the FSM by one cycle.
module uart_tx #(
  parameter int unsigned ClkFreq    = 27000000,
  parameter int unsigned Baud       = 115200,
  parameter int unsigned ClksPerBit = ClkFreq / Baud,
  parameter int unsigned Depth      = 4,
  parameter int unsigned StopBits   = 1
) (
  input  logic       clock,
  input  logic       rst,
  uart_tx_if.slave   host_io,
  output logic       tx_o,
  output logic       busy_o,
  output logic       idle_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [2:0]       StopLast = 3'(StopBits - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            not_full, not_empty;
  logic            push, pop;

  // Serialiser state
  state_e          state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic            baud_last;

  assign not_full  = (count_q != DepthCnt);
  assign not_empty = (count_q != '0);
  // Acceptance looks only at the registered count, so a full FIFO never takes a byte
  // even when a pop happens on the same edge.
  assign push      = host_io.wr_en & not_full;
  assign baud_last = (baud_q == BaudLast);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_io.wr_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (not_empty) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        // bit_q counts stop bits here; chaining straight into START keeps frames gapless.
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == StopLast) begin
            bit_d = '0;
            if (not_empty) begin
              pop     = 1'b1;
              sh_d    = mem_q[rd_ptr_q];
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = sh_q[bit_q];
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != StIdle);
    overflow_d = host_io.wr_en & ~not_full;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign host_io.ready    = not_full;
  assign host_io.overflow = overflow_q;
  assign tx_o             = tx_q;
  assign busy_o           = busy_q;
  assign idle_o           = (count_q == '0) && !busy_q;

  // The line is only ever driven low while a frame is in flight.
  a_count_bound: assert property (@(posedge clock) disable iff (!rst) count_q <= DepthCnt);
  a_low_when_busy: assert property (@(posedge clock) disable iff (!rst) !tx_q |-> busy_q);

endmodule
